// File: rtl/bnn_sequencer_if.sv
// Load/result handshake bundle between the BNN sequencer and its host.
// The host drives pixel beats and acknowledges the classified digit.
interface bnn_sequencer_if #(
    parameter int BEAT_W = 8
);
    logic              start;
    logic [BEAT_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;
    logic [3:0]        digit;
    logic              digit_valid;
    logic              digit_ack;

    modport master (
        output start, data_in, data_valid, digit_ack,
        input  data_ready, digit, digit_valid
    );

    modport slave (
        input  start, data_in, data_valid, digit_ack,
        output data_ready, digit, digit_valid
    );
endinterface

// File: rtl/bnn_sequencer.sv
// BNN classification sequencer: loads a binary image beat by beat,
// steps three layer blocks under a per-layer watchdog, holds the digit.
module bnn_sequencer #(
    parameter int PIX_BITS    = 784,
    parameter int BEAT_W      = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                clk,
    input  logic                rst,
    bnn_sequencer_if.slave      bus,
    output logic [PIX_BITS-1:0] o_pixels,
    output logic [2:0]          o_state,
    output logic                o_layer_rst_n,
    input  logic                i_l1_done,
    input  logic                i_l2_done,
    input  logic                i_l3_done,
    input  logic [3:0]          i_l3_digit,
    output logic                o_busy,
    output logic                o_timeout
);
    localparam int NBEATS = PIX_BITS / BEAT_W;
    localparam int BCW    = $clog2(NBEATS);
    localparam int WDW    = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_LOAD = 3'b001,
        S_L1   = 3'b010,
        S_L2   = 3'b011,
        S_L3   = 3'b100,
        S_OUT  = 3'b101,
        S_ERR  = 3'b110
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [PIX_BITS-1:0] r_pixels;
    logic [BCW-1:0]      r_beat;
    logic [WDW-1:0]      r_wdog;
    logic [3:0]          r_digit;
    logic                w_accept;
    logic                w_last;
    logic                w_done;
    logic                w_expired;
    logic                w_layer;

    assign w_accept  = (r_state == S_LOAD) && bus.data_valid;
    assign w_last    = (r_beat == BCW'(NBEATS - 1));
    assign w_expired = (r_wdog == WDW'(TIMEOUT_CYC - 1));
    assign w_layer   = (r_state == S_L1) || (r_state == S_L2) ||
                       (r_state == S_L3);
    assign w_done    = ((r_state == S_L1) && i_l1_done) ||
                       ((r_state == S_L2) && i_l2_done) ||
                       ((r_state == S_L3) && i_l3_done);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (bus.start) w_next = S_LOAD;
            S_LOAD: if (w_accept && w_last) w_next = S_L1;
            // A done flag beats a watchdog expiry landing on the same cycle
            S_L1: begin
                if (w_done)         w_next = S_L2;
                else if (w_expired) w_next = S_ERR;
            end
            S_L2: begin
                if (w_done)         w_next = S_L3;
                else if (w_expired) w_next = S_ERR;
            end
            S_L3: begin
                if (w_done)         w_next = S_OUT;
                else if (w_expired) w_next = S_ERR;
            end
            S_OUT:  if (bus.digit_ack) w_next = S_IDLE;
            S_ERR:  if (bus.start) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pixels <= '0;
            r_beat   <= '0;
            r_wdog   <= '0;
            r_digit  <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && bus.start)
                r_beat <= '0;
            else if (w_accept)
                r_beat <= r_beat + BCW'(1);
            for (int k = 0; k < NBEATS; k++)
                if (w_accept && (r_beat == BCW'(k)))
                    r_pixels[k*BEAT_W +: BEAT_W] <= bus.data_in;
            if (w_next != r_state)
                r_wdog <= '0;
            else if (w_layer)
                r_wdog <= r_wdog + WDW'(1);
            if ((r_state == S_L3) && i_l3_done)
                r_digit <= i_l3_digit;
        end
    end

    assign bus.data_ready  = (r_state == S_LOAD);
    assign bus.digit       = r_digit;
    assign bus.digit_valid = (r_state == S_OUT);
    assign o_pixels        = r_pixels;
    assign o_state         = r_state;
    assign o_layer_rst_n   = w_layer || (r_state == S_OUT);
    assign o_busy          = (r_state != S_IDLE) && (r_state != S_ERR);
    assign o_timeout       = (r_state == S_ERR);
endmodule

// File: tb/tb_bnn_sequencer.sv
// Directed bench for bnn_sequencer: load, layer stepping, watchdog,
// result handshake and asynchronous reset abort.
module tb_bnn_sequencer;
    localparam int PIX_BITS = 784;
    localparam int BEAT_W   = 8;
    localparam int TMO      = 4096;
    localparam int NBEATS   = PIX_BITS / BEAT_W;

    logic                clk;
    logic                rst;
    logic [PIX_BITS-1:0] pixels;
    logic [2:0]          state;
    logic                layer_rst_n;
    logic                l1_done;
    logic                l2_done;
    logic                l3_done;
    logic [3:0]          l3_digit;
    logic                busy;
    logic                timeout;

    int n_cmp;
    int n_bad;

    bnn_sequencer_if #(.BEAT_W(BEAT_W)) bus ();

    bnn_sequencer #(
        .PIX_BITS(PIX_BITS),
        .BEAT_W(BEAT_W),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .o_pixels(pixels),
        .o_state(state),
        .o_layer_rst_n(layer_rst_n),
        .i_l1_done(l1_done),
        .i_l2_done(l2_done),
        .i_l3_done(l3_done),
        .i_l3_digit(l3_digit),
        .o_busy(busy),
        .o_timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [PIX_BITS-1:0] obs,
                       input logic [PIX_BITS-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    logic [PIX_BITS-1:0] exp_pix;
    logic [PIX_BITS-1:0] pix_a5;
    int n;
    int k;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.data_in = '0;
        bus.data_valid = 1'b0;
        bus.digit_ack = 1'b0;
        l1_done = 1'b0;
        l2_done = 1'b0;
        l3_done = 1'b0;
        l3_digit = 4'd0;
        for (int i = 0; i < NBEATS; i++) pix_a5[i*8 +: 8] = 8'hA5;

        repeat (2) @(negedge clk);
        chk("rst_state", state, 3'b000);
        chk("rst_ready", bus.data_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_lrstn", layer_rst_n, 1'b0);
        chk("rst_pixels", pixels, '0);
        chk("rst_digit", bus.digit, 4'd0);
        chk("rst_dvalid", bus.digit_valid, 1'b0);
        chk("rst_tmo", timeout, 1'b0);
        rst = 1'b0;

        // Full-rate load of 0xA5
        pulse_start();
        chk("load_state", state, 3'b001);
        chk("load_ready", bus.data_ready, 1'b1);
        chk("load_lrstn", layer_rst_n, 1'b0);
        bus.data_valid = 1'b1;
        bus.data_in = 8'hA5;
        n = 0;
        while (state == 3'b001 && n < 300) begin
            @(negedge clk);
            n++;
        end
        bus.data_valid = 1'b0;
        chk("load_cycles", n, 98);
        chk("l1_state", state, 3'b010);
        chk("l1_lrstn", layer_rst_n, 1'b1);
        chk("l1_ready", bus.data_ready, 1'b0);
        chk("pix_a5", pixels, pix_a5);

        // Layers complete 5 cycles after entry
        repeat (5) @(negedge clk);
        l1_done = 1'b1;
        @(negedge clk);
        chk("l2_state", state, 3'b011);
        repeat (5) @(negedge clk);
        l2_done = 1'b1;
        l3_digit = 4'd7;
        @(negedge clk);
        chk("l3_state", state, 3'b100);
        repeat (5) @(negedge clk);
        l3_done = 1'b1;
        @(negedge clk);
        chk("out_state", state, 3'b101);
        chk("out_digit", bus.digit, 4'd7);
        chk("out_dvalid", bus.digit_valid, 1'b1);
        chk("out_busy", busy, 1'b1);
        l1_done = 1'b0;
        l2_done = 1'b0;
        l3_done = 1'b0;
        l3_digit = 4'd2;
        repeat (10) @(negedge clk);
        chk("out_hold", state, 3'b101);
        chk("out_hold_dig", bus.digit, 4'd7);
        bus.digit_ack = 1'b1;
        @(negedge clk);
        bus.digit_ack = 1'b0;
        chk("ack_state", state, 3'b000);
        chk("ack_dvalid", bus.digit_valid, 1'b0);
        chk("ack_digit", bus.digit, 4'd7);
        chk("idle_busy", busy, 1'b0);

        // Half-rate load, distinct beats
        pulse_start();
        chk("pix_keep", pixels, pix_a5);
        n = 0;
        k = 0;
        while (state == 3'b001 && n < 400) begin
            bus.data_valid = n[0];
            bus.data_in = 8'(k) ^ 8'h5A;
            @(negedge clk);
            if (bus.data_valid) k++;
            n++;
        end
        bus.data_valid = 1'b0;
        for (int i = 0; i < NBEATS; i++) exp_pix[i*8 +: 8] = 8'(i) ^ 8'h5A;
        chk("half_cycles", n, 196);
        chk("half_pixels", pixels, exp_pix);
        chk("half_state", state, 3'b010);

        // l1_done on the last watchdog count wins
        repeat (TMO - 1) @(negedge clk);
        l1_done = 1'b1;
        @(negedge clk);
        chk("edge_state", state, 3'b011);
        chk("edge_tmo", timeout, 1'b0);

        // L2 never completes; start in L2 ignored
        n = 0;
        while (state == 3'b011 && n < 5000) begin
            bus.start = (n == 10);
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        l1_done = 1'b0;
        chk("wd_cycles", n, TMO);
        chk("err_state", state, 3'b110);
        chk("err_tmo", timeout, 1'b1);
        chk("err_busy", busy, 1'b0);
        chk("err_lrstn", layer_rst_n, 1'b0);
        repeat (3) @(negedge clk);
        chk("err_sticky", timeout, 1'b1);
        pulse_start();
        chk("err_exit", state, 3'b000);
        chk("err_clr", timeout, 1'b0);

        // Asynchronous reset during beat 50
        pulse_start();
        bus.data_valid = 1'b1;
        bus.data_in = 8'hFF;
        repeat (50) @(negedge clk);
        chk("mid_state", state, 3'b001);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_state", state, 3'b000);
        chk("arst_pixels", pixels, '0);
        chk("arst_ready", bus.data_ready, 1'b0);
        chk("arst_busy", busy, 1'b0);
        bus.data_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        chk("post_rst_start", state, 3'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bnn_sequencer.md
BNN_SEQUENCER -- requirements
Module: bnn_sequencer

Interface
REQ-001 Parameter PIX_BITS, default 784, is the image size in bits (28x28 binary pixels).
REQ-002 Parameter BEAT_W, default 8, is the pixel bits per load beat; PIX_BITS/BEAT_W = 98 beats.
REQ-003 Parameter TIMEOUT_CYC, default 4096, is the per-layer watchdog limit in cycles.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 start  in  1  single-cycle request to begin a classification.
REQ-008 data_in  in  BEAT_W  pixel beat; bit 0 = lowest-index pixel of the beat.
REQ-009 data_valid  in  1  data_in valid.
REQ-010 data_ready  out  1  sequencer accepts a beat this cycle.
REQ-011 pixels  out  PIX_BITS  assembled image to layer datapath.
REQ-012 state  out  3  global phase code broadcast to all layers.
REQ-013 layer_rst_n  out  1  active-low synchronous reset to layer blocks.
REQ-014 l1_done, l2_done, l3_done  in  1 each  layer completion flags, level, held until layer reset.
REQ-015 l3_digit  in  4  classified digit from final layer.
REQ-016 digit  out  4  latched result.
REQ-017 digit_valid  out  1  result available.
REQ-018 digit_ack  in  1  consumer accepts result.
REQ-019 busy  out  1  high in any state except IDLE and ERR.
REQ-020 timeout  out  1  sticky watchdog error flag.

Function
REQ-021 FSM state codes SHALL be IDLE=000, LOAD=001, L1=010, L2=011, L3=100, OUT=101, ERR=110; state output SHALL equal the registered code.
REQ-022 IDLE: start=1 -> LOAD next cycle, beat counter cleared to 0; start ignored in all other states except ERR.
REQ-023 data_ready SHALL be 1 exactly when state=LOAD.
REQ-024 Beat accepted when data_valid & data_ready; beat k written to pixels[BEAT_W*k+BEAT_W-1 : BEAT_W*k], counter increments; unaccepted cycles change nothing.
REQ-025 Acceptance of beat 97 -> L1 next cycle; minimum LOAD duration 98 cycles.
REQ-026 pixels SHALL hold its value outside LOAD and is not cleared on start (fully overwritten by load).
REQ-027 layer_rst_n SHALL be 0 in IDLE, LOAD, ERR and 1 in L1, L2, L3, OUT.
REQ-028 L1 -> L2 the cycle after l1_done=1 is sampled; L2 -> L3 on l2_done; L3 -> OUT on l3_done, capturing l3_digit into digit on that same edge.
REQ-029 Watchdog counter (width ceil(log2 TIMEOUT_CYC)) SHALL clear on entry to each of L1/L2/L3 and increment each cycle in that state.
REQ-030 Counter = TIMEOUT_CYC-1 with the current layer done=0 -> ERR next cycle, timeout set to 1.
REQ-031 Done and watchdog expiry in the same cycle: done wins, normal transition.
REQ-032 OUT: digit_valid=1, digit stable; on digit_valid & digit_ack -> IDLE next cycle with digit_valid=0; digit retains value.
REQ-033 ERR: timeout held 1; start=1 -> IDLE next cycle, timeout cleared; no other exit.
REQ-034 busy SHALL be combinationally derived from registered state only.

Reset
REQ-035 rst=1 SHALL immediately, without clock, force state=IDLE, pixels=0, beat counter=0, watchdog=0, digit=0, digit_valid=0, timeout=0; hence data_ready=0, busy=0, layer_rst_n=0.
REQ-036 rst asserted mid-LOAD or mid-layer SHALL abort the operation; partial pixels discarded (cleared).
REQ-037 After rst deasserts, first start is honoured on the first rising edge.

Verification
REQ-038 Reset, start, 98 beats with data_valid=1 of 0xA5 -> state 001 for 98 cycles, then 010; pixels = 0xA5 repeated; layer_rst_n rises with L1.
REQ-039 data_valid toggled 1/0 during load -> exactly 98 accepted beats over 196 cycles, beat order preserved.
REQ-040 l1/l2/l3_done raised 5 cycles after each layer entry, l3_digit=7 -> state 010,011,100,101; digit=7, digit_valid=1; digit_ack held 0 for 10 cycles keeps OUT; ack=1 -> IDLE next cycle.
REQ-041 l2_done never asserted -> L2 for exactly TIMEOUT_CYC cycles, then state 110, timeout=1, busy=0; start -> IDLE, timeout=0.
REQ-042 l1_done asserted on the cycle counter = TIMEOUT_CYC-1 -> L2, timeout stays 0.
REQ-043 rst pulsed mid-clock during beat 50 -> outputs reset asynchronously, pixels=0, state 000; start during L2 ignored.
